// File: rtl/traffic_gen_engine_if.sv
// Word stream bundle shared between the traffic generator engine and the
// streamer. A word moves when valid and ready are both high on a clock edge.
//   data  : stream word
//   strb  : byte strobes (DATA_WIDTH/8 bits)
//   valid : producer has a word on data/strb
//   ready : consumer accepts the word this cycle
// Modports: source/master drive valid/data/strb; sink/slave drive ready.
interface hwpe_stream_intf_stream #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/traffic_gen_engine.sv
// Datapath engine of the traffic generator. Consumes words from r_reqs,
// applies a per-job transform (pass / xor key / add key / rotate-left) and
// emits them on w_reqs through a single output register (1 cycle latency,
// 1 word/cycle throughput). A job is len_i words started from IDLE.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   enable_i      : low stalls the engine (state held)
//   clear_i       : synchronous clear back to reset values
//   r_reqs        : input word stream (sink)
//   w_reqs        : output word stream (source), strb always all ones
//   start_i, len_i, op_i, key_i : job launch and configuration
//   busy_o, done_o, cnt_o, checksum_o : job status
module traffic_gen_engine #(
  parameter int LEN_WIDTH  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  clear_i,
  hwpe_stream_intf_stream.sink   r_reqs,
  hwpe_stream_intf_stream.source w_reqs,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [1:0]            op_i,
  input  logic [31:0]           key_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  cnt_o,
  output logic [31:0]           checksum_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, in_cnt_q, cnt_q;
  logic [1:0]             op_q;
  logic [31:0]            key_q;
  logic [31:0]            csum_q;
  logic [DATA_WIDTH-1:0]  data_p1;
  logic                   vld_p1;

  logic                   r_ready, in_hs, out_hs, last_out, start_ok;
  logic [LEN_WIDTH-1:0]   cnt_inc;
  logic                   unused_strb;

  function automatic logic [31:0] xform(input logic [1:0] op,
                                        input logic [31:0] key,
                                        input logic [31:0] d);
    logic [63:0] dd;
    logic [31:0] r;
    dd = {d, d} << key[4:0];
    unique case (op)
      2'd0:    r = d;
      2'd1:    r = d ^ key;
      2'd2:    r = d + key;
      default: r = dd[63:32];
    endcase
    return r;
  endfunction

  // Input strobes carry no meaning for the transform.
  assign unused_strb = ^r_reqs.strb;

  // Accept only while the output register is free or draining this cycle.
  assign r_ready  = (state_q == RUN) & enable_i & (in_cnt_q < len_q) &
                    (!vld_p1 | w_reqs.ready);
  assign in_hs    = r_ready & r_reqs.valid;
  // The output handshake is honoured even while stalled so a word the
  // consumer already took is never counted twice or lost.
  assign out_hs   = vld_p1 & w_reqs.ready;
  assign cnt_inc  = cnt_q + LEN_WIDTH'(1);
  assign last_out = out_hs & (cnt_inc == len_q);
  assign start_ok = (state_q == IDLE) & enable_i & start_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = (len_i == '0) ? DONE : RUN;
      RUN:  if (last_out) state_d = DONE;
      DONE: if (enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q    <= '0;
      op_q     <= '0;
      key_q    <= '0;
      in_cnt_q <= '0;
      cnt_q    <= '0;
      csum_q   <= '0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
    end else if (clear_i) begin
      len_q    <= '0;
      op_q     <= '0;
      key_q    <= '0;
      in_cnt_q <= '0;
      cnt_q    <= '0;
      csum_q   <= '0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q    <= len_i;
        op_q     <= op_i;
        key_q    <= key_i;
        in_cnt_q <= '0;
        cnt_q    <= '0;
        csum_q   <= '0;
      end
      // p0 -> p1: transformed input word lands in the output register
      if (in_hs) begin
        data_p1  <= xform(op_q, key_q, r_reqs.data);
        vld_p1   <= 1'b1;
        in_cnt_q <= in_cnt_q + LEN_WIDTH'(1);
      end else if (out_hs) begin
        vld_p1   <= 1'b0;
      end
      if (out_hs) begin
        cnt_q  <= cnt_inc;
        csum_q <= csum_q + data_p1;
      end
    end
  end

  assign r_reqs.ready = r_ready;
  assign w_reqs.valid = vld_p1;
  assign w_reqs.data  = data_p1;
  assign w_reqs.strb  = '1;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign cnt_o        = cnt_q;
  assign checksum_o   = csum_q;

endmodule

// File: tb/tb_traffic_gen_engine.sv
module tb_traffic_gen_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic        start;
  logic [15:0] len;
  logic [1:0]  op;
  logic [31:0] key;
  logic        busy, done;
  logic [15:0] cnt;
  logic [31:0] csum;

  int total = 0;
  int bad   = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) r_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) w_if ();

  traffic_gen_engine #(.LEN_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .clear_i    (clear),
    .r_reqs     (r_if),
    .w_reqs     (w_if),
    .start_i    (start),
    .len_i      (len),
    .op_i       (op),
    .key_i      (key),
    .busy_o     (busy),
    .done_o     (done),
    .cnt_o      (cnt),
    .checksum_o (csum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] in_words[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_f(input logic [1:0] o, input logic [31:0] k,
                                          input logic [31:0] d);
    logic [31:0] r;
    case (o)
      2'd0: r = d;
      2'd1: r = d ^ k;
      2'd2: r = d + k;
      default: begin
        r = d;
        for (int i = 0; i < int'(k[4:0]); i++) r = {r[30:0], r[31]};
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] n, input logic [1:0] o, input logic [31:0] k);
    start = 1'b1; len = n; op = o; key = k;
    tick();
    start = 1'b0;
  endtask

  // One-word job with the output always ready.
  task automatic run_single(input vec_t v);
    launch(16'd1, v.op, v.key);
    w_if.ready = 1'b1;
    r_if.valid = 1'b1;
    r_if.data  = v.din;
    #1;
    check("single_rready", {31'd0, r_if.ready}, 32'd1);
    tick();
    r_if.valid = 1'b0;
    check("single_wvalid", {31'd0, w_if.valid}, 32'd1);
    check("single_data", w_if.data, v.dout);
    tick();
    check("single_done", {31'd0, done}, 32'd1);
    check("single_csum", csum, v.dout);
    tick();
    check("single_idle", {31'd0, busy}, 32'd0);
  endtask

  // Streams n words of in_words through a job; w ready follows rpat (4 cycles).
  task automatic run_job(input int n, input logic [1:0] o, input logic [31:0] k,
                         input logic [3:0] rpat, input int exp_cycles);
    logic [31:0] exp_sum = 0;
    logic [31:0] held_d  = 0;
    logic        held_v  = 1'b0;
    int sent = 0, recv = 0, cyc = 0;
    launch(16'(n), o, k);
    check("job_busy", {31'd0, busy}, 32'd1);
    while (!done && cyc < 200) begin
      r_if.valid = 1'b1;
      r_if.data  = (sent < n) ? in_words[sent] : 32'hDEADBEEF;
      w_if.ready = rpat[cyc % 4];
      #2;
      if (held_v) begin
        check("hold_valid", {31'd0, w_if.valid}, 32'd1);
        check("hold_data", w_if.data, held_d);
      end
      if (w_if.valid && !w_if.ready)
        check("bp_rready", {31'd0, r_if.ready}, 32'd0);
      if (r_if.ready && r_if.valid) begin
        if (sent >= n) check("extra_accept", 32'd1, 32'd0);
        sent++;
      end
      if (w_if.valid && w_if.ready) begin
        if (recv < n) begin
          check("job_data", w_if.data, model_f(o, k, in_words[recv]));
          exp_sum += model_f(o, k, in_words[recv]);
        end else begin
          check("extra_output", 32'd1, 32'd0);
        end
        recv++;
      end
      held_v = w_if.valid & !w_if.ready;
      held_d = w_if.data;
      tick();
      cyc++;
    end
    r_if.valid = 1'b0;
    check("job_done", {31'd0, done}, 32'd1);
    check("job_sent", sent, n);
    check("job_recv", recv, n);
    check("job_cnt", {16'd0, cnt}, n);
    check("job_csum", csum, exp_sum);
    if (exp_cycles > 0) check("job_cycles", cyc, exp_cycles);
    tick();
    check("job_done_pulse", {31'd0, done}, 32'd0);
    check("job_end_idle", {31'd0, busy}, 32'd0);
    check("job_cnt_hold", {16'd0, cnt}, n);
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'hA5A5A5A5, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[1] = '{2'd1, 32'hFFFF0000, 32'h12345678, 32'hEDCB5678};
    vecs[2] = '{2'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};
    vecs[3] = '{2'd3, 32'h00000004, 32'h80000001, 32'h00000018};
    vecs[4] = '{2'd3, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5] = '{2'd3, 32'h00000020, 32'h0F0F0000, 32'h0F0F0000};
    vecs[6] = '{2'd3, 32'h0000001F, 32'h00000003, 32'h80000001};
    vecs[7] = '{2'd3, 32'h00000008, 32'h12345678, 32'h34567812};
    vecs[8] = '{2'd2, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[9] = '{2'd1, 32'h00000000, 32'h13572468, 32'h13572468};

    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; start = 1'b0;
    len = '0; op = '0; key = '0;
    r_if.valid = 1'b0; r_if.data = '0; r_if.strb = 4'h0; w_if.ready = 1'b0;
    repeat (2) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wvalid", {31'd0, w_if.valid}, 32'd0);
    check("rst_wdata", w_if.data, 32'd0);
    check("rst_wstrb", {28'd0, w_if.strb}, 32'hF);
    check("rst_rready", {31'd0, r_if.ready}, 32'd0);
    check("rst_cnt", {16'd0, cnt}, 32'd0);
    check("rst_csum", csum, 32'd0);
    rst_n = 1'b1;
    tick();

    // Pass-through, full throughput: 4 words done after 5 cycles.
    in_words[0] = 32'h1; in_words[1] = 32'h2; in_words[2] = 32'h3; in_words[3] = 32'h4;
    run_job(4, 2'd0, 32'h0, 4'b1111, 5);
    check("pass_csum", csum, 32'hA);

    for (int i = 0; i < 10; i++) run_single(vecs[i]);

    // Backpressure with ready pattern 1,0,0,1.
    for (int i = 0; i < 8; i++) in_words[i] = 32'h1000_0000 * (i + 1) + 32'h11 * i;
    run_job(8, 2'd2, 32'h10, 4'b1001, 0);
    check("bp_cnt8", {16'd0, cnt}, 32'd8);

    // Zero-length job.
    launch(16'd0, 2'd0, 32'h0);
    check("zl_rready0", {31'd0, r_if.ready}, 32'd0);
    check("zl_busy", {31'd0, busy}, 32'd1);
    check("zl_done", {31'd0, done}, 32'd1);
    check("zl_cnt", {16'd0, cnt}, 32'd0);
    check("zl_csum", csum, 32'd0);
    tick();
    check("zl_rready1", {31'd0, r_if.ready}, 32'd0);
    check("zl_idle", {31'd0, busy}, 32'd0);
    check("zl_done_off", {31'd0, done}, 32'd0);

    // Stall: enable low for 5 cycles with a word pending in the output.
    launch(16'd4, 2'd0, 32'h0);
    w_if.ready = 1'b1; r_if.valid = 1'b1; r_if.data = 32'h11;
    tick();
    r_if.data = 32'h22;
    tick();
    check("st_pre_data", w_if.data, 32'h22);
    check("st_pre_cnt", {16'd0, cnt}, 32'd1);
    enable = 1'b0; w_if.ready = 1'b0; r_if.data = 32'h33;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_rready", {31'd0, r_if.ready}, 32'd0);
      check("st_wvalid", {31'd0, w_if.valid}, 32'd1);
      check("st_wdata", w_if.data, 32'h22);
      check("st_cnt", {16'd0, cnt}, 32'd1);
      tick();
    end
    enable = 1'b1; w_if.ready = 1'b1;
    start = 1'b1; len = 16'd1;   // ignored outside IDLE
    tick();
    start = 1'b0;
    check("st_d33", w_if.data, 32'h33);
    check("st_cnt2", {16'd0, cnt}, 32'd2);
    r_if.data = 32'h44;
    tick();
    check("st_d44", w_if.data, 32'h44);
    r_if.valid = 1'b0;
    tick();
    check("st_done", {31'd0, done}, 32'd1);
    check("st_cnt4", {16'd0, cnt}, 32'd4);
    check("st_csum", csum, 32'hAA);
    tick();

    // Clear mid-job.
    launch(16'd4, 2'd1, 32'h5);
    r_if.valid = 1'b1; r_if.data = 32'h100;
    tick(); tick();
    r_if.valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_wvalid", {31'd0, w_if.valid}, 32'd0);
    check("clr_csum", csum, 32'd0);
    check("clr_cnt", {16'd0, cnt}, 32'd0);
    in_words[0] = 32'hF0; in_words[1] = 32'h0F; in_words[2] = 32'hAA55;
    run_job(3, 2'd1, 32'h5, 4'b1111, 4);

    // Asynchronous reset between clock edges.
    launch(16'd4, 2'd0, 32'h0);
    w_if.ready = 1'b1; r_if.valid = 1'b1; r_if.data = 32'h77;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_wvalid", {31'd0, w_if.valid}, 32'd0);
    check("ar_wdata", w_if.data, 32'd0);
    check("ar_cnt", {16'd0, cnt}, 32'd0);
    check("ar_csum", csum, 32'd0);
    check("ar_rready", {31'd0, r_if.ready}, 32'd0);
    r_if.valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    in_words[0] = 32'h9; in_words[1] = 32'h8;
    run_job(2, 2'd3, 32'h1, 4'b1111, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
